// File: rtl/pipe_pkg.sv
// pipe_pkg: opcode constants, issue-controller states and decode helpers shared by D-stage logic
package pipe_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

    // One in-flight instruction as seen by the hazard tracker
    typedef struct packed {
        logic       v;
        logic       w;
        logic [4:0] rd;
    } trk_entry_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B, OP_IMM, OP_LOAD, OP_JALR, OP_SYS};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

endpackage

// File: rtl/reg_tracker.sv
// reg_tracker: X/M/W image of in-flight destination registers with source-match logic
module reg_tracker
    import pipe_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       freeze,
    input  trk_entry_t load,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard_rs1,
    output logic       hazard_rs2,
    output logic       pipe_empty
);

    trk_entry_t x_q, m_q, w_q;

    function automatic logic hit(input trk_entry_t e, input logic [4:0] rs);
        return e.v && e.w && e.rd == rs;
    endfunction

    // Shift the in-flight image one stage per unfrozen edge; X takes whatever D sends
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!freeze) begin
            w_q <= m_q;
            m_q <= x_q;
            x_q <= load;
        end
    end

    assign hazard_rs1 = hit(x_q, rs1) | hit(m_q, rs1) | hit(w_q, rs1);
    assign hazard_rs2 = hit(x_q, rs2) | hit(m_q, rs2) | hit(w_q, rs2);

    // True when X, M and W will all be invalid once the coming edge has shifted:
    // whatever sits in W now retires on that edge
    assign pipe_empty = !x_q.v && !m_q.v && !load.v;

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: RAW-hazard interlock, branch squash, memory freeze and ECALL drain/halt for the 5-stage pipe
module issue_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [6:0]       d_opcode,
    input  logic [4:0]       d_rd,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             redirect,
    input  logic             mem_ready,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_flush,
    output logic             x_bubble,
    output logic             issue,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hz_rs1, hz_rs2, hazard, drain_done;
    trk_entry_t       x_load;

    assign hazard = d_valid && ((uses_rs1(d_opcode) && hz_rs1) || (uses_rs2(d_opcode) && hz_rs2));

    // Only an issuing instruction occupies X; x0 destinations never count as writes
    assign x_load = '{v: issue, w: issue && writes_rd(d_opcode) && d_rd != 5'd0, rd: d_rd};

    reg_tracker u_trk (
        .clock      (clock),
        .reset      (reset),
        .freeze     (!mem_ready),
        .load       (x_load),
        .rs1        (d_rs1),
        .rs2        (d_rs2),
        .hazard_rs1 (hz_rs1),
        .hazard_rs2 (hz_rs2),
        .pipe_empty (drain_done)
    );

    // Pipeline control in priority order: reset, memory freeze, redirect, drain/halt, hazard
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_flush  = 1'b0;
        x_bubble = 1'b0;
        issue    = 1'b0;
        if (!reset) begin
            if (!mem_ready) begin
                f_stall = 1'b1;
                d_stall = 1'b1;
            end else if (redirect && state_q == RUN) begin
                d_flush  = 1'b1;
                x_bubble = 1'b1;
            end else if (state_q != RUN || hazard) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                x_bubble = 1'b1;
            end else begin
                issue = d_valid;
            end
        end
    end

    // Run/drain/halt sequencing and saturating hazard-stall counter, both held while memory is busy
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (mem_ready) begin
            case (state_q)
                RUN:     if (issue && d_opcode == OP_SYS) state_q <= DRAIN;
                DRAIN:   if (drain_done) state_q <= HALT;
                default: state_q <= state_q;
            endcase
            if (state_q == RUN && !redirect && hazard && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign halted       = state_q == HALT;
    assign stall_cycles = cnt_q;

endmodule
